priority_event_fifo: RTL and testbench
======================================

PRIORITY_EVENT_FIFO -- requirements
Module: priority_event_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of FIFO entries; power of two, 2..16.
REQ-002 The block SHALL have parameter CODE_W, default 4: width of the priority-encoder index (16 request lines).
REQ-003 The block SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1: encoder "any request asserted" flag.
REQ-006 The block SHALL have port in_code, input, CODE_W: encoder index of the highest-priority asserted request.
REQ-007 The block SHALL have port pop, input, 1: consumer removes the head entry.
REQ-008 The block SHALL have port out_valid, output, 1: head entry present (FIFO not empty).
REQ-009 The block SHALL have port out_code, output, CODE_W: head entry code; 0 when empty.
REQ-010 The block SHALL have port count, output, log2(DEPTH)+1: number of stored entries.
REQ-011 The block SHALL have port full, output, 1: count == DEPTH.
REQ-012 The block SHALL have port drop_cnt, output, 8: number of events lost to overflow, saturating.

Function
REQ-013 The block SHALL register in_valid/in_code each cycle into last_valid/last_code.
REQ-014 The block SHALL raise an event when in_valid=1 and (last_valid=0 or in_code != last_code); a held code SHALL NOT re-trigger.
REQ-015 The block SHALL treat in_valid=0 as no event and SHALL clear last_valid, so that a later return of the same code re-triggers.
REQ-016 The block SHALL write each event into the FIFO at the tail on the same edge; the entry is visible at out_code one cycle after the triggering input (no combinational bypass).
REQ-017 The block SHALL present the head entry show-ahead: out_code is valid whenever out_valid=1, with no read latency.
REQ-018 The block SHALL retire the head on the edge where pop=1 and out_valid=1; pop while empty SHALL be ignored with no state change.
REQ-019 The block SHALL accept an event when full and pop=1 in the same cycle; count stays DEPTH and no drop is recorded.
REQ-020 The block SHALL discard an event when full and pop=0, increment drop_cnt, saturate it at 255, and leave FIFO contents unchanged.
REQ-021 The block SHALL increment count on a lone push, decrement it on a lone pop, and hold it on simultaneous push and pop.
REQ-022 The block SHALL wrap read/write pointers modulo DEPTH with no gap or duplicate entry.
REQ-023 The block SHALL drive out_valid = (count != 0) and full = (count == DEPTH) from registered state only.
REQ-024 The block SHALL accept an event when empty with simultaneous pop: the pop is ignored and the event is stored (count becomes 1).

Reset
REQ-025 While rst=1 at a rising edge, the block SHALL clear pointers, count, drop_cnt, last_valid and last_code, and SHALL ignore in_valid and pop that cycle.
REQ-026 After reset, the block SHALL drive out_valid=0, out_code=0, count=0, full=0 and drop_cnt=0 until the first event.
REQ-027 An assertion of rst mid-operation SHALL discard all stored entries; an in_code still held after rst deasserts SHALL be captured as a new event on the first non-reset edge.

Verification
REQ-028 The bench SHALL verify: reset, then in_valid=1 with in_code=0xF held 5 cycles -> exactly one entry; out_code=0xF one cycle after input; count=1.
REQ-029 The bench SHALL verify: codes 3, 7, 3 on consecutive cycles, no pop -> count=3; pops return 3, 7, 3 in order; out_valid=0 after the third pop.
REQ-030 The bench SHALL verify: 6 distinct codes with DEPTH=4 and no pop -> full=1, count=4, drop_cnt=2; head is the first code.
REQ-031 The bench SHALL verify: full, then a new code with pop=1 in the same cycle -> count stays 4, drop_cnt unchanged, new code at tail.
REQ-032 The bench SHALL verify: in_valid toggling 1,0,1 with in_code=0x8 -> two entries of 0x8; 300 overflow events -> drop_cnt=255.
REQ-033 The bench SHALL verify: rst pulsed for 1 cycle with 2 entries stored and in_code=0x5 held -> count=0 during reset, then one 0x5 entry appears after release.

Source files
------------

// File: rtl/priority_event_fifo.sv
// priority_event_fifo: edge-detects priority-encoder codes and queues each new code in a show-ahead FIFO
module priority_event_fifo #(
  parameter int DEPTH  = 4,
  parameter int CODE_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [CODE_W-1:0]          in_code,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [CODE_W-1:0]          out_code,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic [7:0]                 drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_N = CW'(DEPTH);
  logic [CODE_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CODE_W-1:0] last_code;
  logic last_valid, ev, do_pop, do_push, drop;
  // A held code does not re-trigger; a dropped in_valid re-arms the detector.
  // A full FIFO still accepts an event when the head leaves on the same edge.
  always_comb begin
    ev        = in_valid && (!last_valid || in_code != last_code);
    out_valid = count != '0;
    full      = count == DEPTH_N;
    do_pop    = pop && out_valid;
    do_push   = ev && (!full || do_pop);
    drop      = ev && full && !pop;
    out_code  = out_valid ? mem[rd_ptr] : '0;
  end
  // Storage array; contents need no reset because out_code is masked while empty.
  always_ff @(posedge clk)
    if (!rst && do_push) mem[wr_ptr] <= in_code;
  // Pointers, occupancy, overflow counter and the input history register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_cnt   <= '0;
      last_valid <= 1'b0;
      last_code  <= '0;
    end else begin
      last_valid <= in_valid;
      last_code  <= in_code;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop) count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_priority_event_fifo.sv
// tb_priority_event_fifo: directed self-checking bench for priority_event_fifo
module tb_priority_event_fifo;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, pop = 1'b0;
  logic [3:0] in_code = 4'h0, out_code;
  logic out_valid, full;
  logic [2:0] count;
  logic [7:0] drop_cnt;
  int checks = 0, failures = 0;

  priority_event_fifo #(.DEPTH(4), .CODE_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .pop(pop),
    .out_valid(out_valid), .out_code(out_code), .count(count), .full(full),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_expect(input string tag, input logic [3:0] exp);
    chk(tag, {31'd0, out_valid}, 32'd1);
    chk(tag, {28'd0, out_code}, {28'd0, exp});
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_count", {29'd0, count}, 0);
    rst = 1'b0;
    step();
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_code", {28'd0, out_code}, 0);
    chk("rst_count2", {29'd0, count}, 0);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_drop", {24'd0, drop_cnt}, 0);

    in_valid = 1'b1; in_code = 4'hF;
    step();
    chk("hold_code1", {28'd0, out_code}, 32'hF);
    chk("hold_count1", {29'd0, count}, 1);
    repeat (4) step();
    in_valid = 1'b0;
    step();
    chk("hold_count5", {29'd0, count}, 1);
    pop_expect("hold_pop", 4'hF);
    chk("hold_empty", {31'd0, out_valid}, 0);

    in_valid = 1'b1; in_code = 4'h3; step();
    in_code = 4'h7; step();
    in_code = 4'h3; step();
    in_valid = 1'b0; step();
    chk("seq_count", {29'd0, count}, 3);
    pop_expect("seq_pop0", 4'h3);
    pop_expect("seq_pop1", 4'h7);
    pop_expect("seq_pop2", 4'h3);
    chk("seq_empty", {31'd0, out_valid}, 0);

    in_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_code = 4'(i);
      step();
    end
    in_valid = 1'b0; step();
    chk("ovf_full", {31'd0, full}, 1);
    chk("ovf_count", {29'd0, count}, 4);
    chk("ovf_drop", {24'd0, drop_cnt}, 2);
    chk("ovf_head", {28'd0, out_code}, 1);

    in_valid = 1'b1; in_code = 4'h9; pop = 1'b1;
    step();
    in_valid = 1'b0; pop = 1'b0;
    chk("fullpp_count", {29'd0, count}, 4);
    chk("fullpp_drop", {24'd0, drop_cnt}, 2);
    pop_expect("fullpp_pop0", 4'h2);
    pop_expect("fullpp_pop1", 4'h3);
    pop_expect("fullpp_pop2", 4'h4);
    pop_expect("fullpp_tail", 4'h9);
    chk("fullpp_empty", {29'd0, count}, 0);

    in_code = 4'h8;
    in_valid = 1'b1; step();
    in_valid = 1'b0; step();
    in_valid = 1'b1; step();
    in_valid = 1'b0; step();
    chk("tog_count", {29'd0, count}, 2);
    pop_expect("tog_pop0", 4'h8);
    pop_expect("tog_pop1", 4'h8);

    in_valid = 1'b1;
    for (int i = 0; i < 304; i++) begin
      in_code = (i % 2 == 0) ? 4'hA : 4'hB;
      step();
    end
    in_valid = 1'b0; step();
    chk("sat_drop", {24'd0, drop_cnt}, 255);
    chk("sat_count", {29'd0, count}, 4);

    pop_expect("rst2_pop0", 4'hA);
    pop_expect("rst2_pop1", 4'hB);
    chk("rst2_pre", {29'd0, count}, 2);
    in_valid = 1'b1; in_code = 4'h5; rst = 1'b1;
    step();
    chk("rst2_count", {29'd0, count}, 0);
    chk("rst2_drop", {24'd0, drop_cnt}, 0);
    rst = 1'b0;
    step();
    chk("rst2_cap_count", {29'd0, count}, 1);
    chk("rst2_cap_code", {28'd0, out_code}, 5);
    step();
    chk("rst2_hold", {29'd0, count}, 1);
    in_valid = 1'b0;
    pop_expect("rst2_pop", 4'h5);

    in_valid = 1'b1; in_code = 4'h6; pop = 1'b1;
    step();
    in_valid = 1'b0; pop = 1'b0;
    chk("emptypp_count", {29'd0, count}, 1);
    chk("emptypp_code", {28'd0, out_code}, 6);
    pop = 1'b1; step(); step(); pop = 1'b0;
    chk("emptypop_count", {29'd0, count}, 0);
    chk("emptypop_code", {28'd0, out_code}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
